// File: rtl/wddl_phase_ctrl.sv
// wddl_phase_ctrl: precharge/evaluate sequencer for a WDDL gate array.
// Accepts one operand per start_i/ready_o handshake and drives it to the
// datapath. Runs PRE_CYC precharge cycles, then EVAL_CYC evaluate cycles,
// then captures the true result rail.
// Optional build macro WDDL_RAIL_CHECK_EN enables rail-integrity checking
// into the sticky err_o. Without it, err_o is tied to 0.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | precharge held, ready for a new operand
// PRE   | precharge phase, counter runs down from PRE_CYC-1
// EVAL  | evaluate phase, counter runs down from EVAL_CYC-1; capture at 0
module wddl_phase_ctrl #(
  parameter int DATA_W   = 8,
  parameter int PRE_CYC  = 1,
  parameter int EVAL_CYC = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              prechrg_o,
  output logic [DATA_W-1:0] op_data_o,
  input  logic [DATA_W-1:0] res_t_i,
  input  logic [DATA_W-1:0] res_f_i,
  output logic [DATA_W-1:0] result_o,
  output logic              valid_o,
  input  logic              err_clr_i,
  output logic              err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_EVAL = 2'd2
  } state_t;

  localparam logic [7:0] PRE_LD  = 8'(PRE_CYC - 1);
  localparam logic [7:0] EVAL_LD = 8'(EVAL_CYC - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              prechrg_q, prechrg_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [DATA_W-1:0] res_q, res_d;

  logic accept, pre_done, capture;

  assign accept   = (state_q == S_IDLE) && start_i;
  assign pre_done = (state_q == S_PRE)  && (cnt_q == 8'd0);
  assign capture  = (state_q == S_EVAL) && (cnt_q == 8'd0);

  // State, phase counter and all registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      prechrg_q <= 1'b1;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      op_q      <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prechrg_q <= prechrg_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      op_q      <= op_d;
      res_q     <= res_d;
    end
  end

  // Next state and phase counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_PRE;
          cnt_d   = PRE_LD;
        end
      end
      S_PRE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_EVAL;
          cnt_d   = EVAL_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_EVAL: begin
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    prechrg_d = (state_d != S_EVAL);
    ready_d   = (state_d == S_IDLE);
    valid_d   = capture;
    op_d      = accept  ? data_i  : op_q;
    res_d     = capture ? res_t_i : res_q;
  end

`ifdef WDDL_RAIL_CHECK_EN
  logic rail_viol;

  // Rails must be all-low at the end of precharge and complementary at capture
  always_comb begin
    rail_viol = (pre_done && (|(res_t_i | res_f_i))) ||
                (capture  && (|(~(res_t_i ^ res_f_i))));
    if (rail_viol) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end
`else
  logic unused_rail_inputs;

  assign unused_rail_inputs = ^{res_f_i, err_clr_i, pre_done};

  // No checking hardware: flag is held low
  always_comb begin
    err_d = 1'b0;
  end
`endif

  assign prechrg_o = prechrg_q;
  assign ready_o   = ready_q;
  assign valid_o   = valid_q;
  assign err_o     = err_q;
  assign op_data_o = op_q;
  assign result_o  = res_q;

endmodule

// File: tb/tb_wddl_phase_ctrl.sv
// Bench for wddl_phase_ctrl: default instance (u0) plus PRE_CYC=3/EVAL_CYC=2
// instance (u1). Drivers push expected results and capture cycles into
// queues; a monitor pops and compares on every valid_o pulse.
module tb_wddl_phase_ctrl;

`ifdef WDDL_RAIL_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  typedef struct {
    logic [7:0] res;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_fail;

  exp_t q0[$];
  exp_t q1[$];

  logic       start0, ready0, prechrg0, valid0, err_clr0, err0;
  logic [7:0] data0, op0, res_t0, res_f0, result0;
  logic [7:0] rt0_pre, rf0_pre, rt0_ev, rf0_ev;

  logic       start1, ready1, prechrg1, valid1, err_clr1, err1;
  logic [7:0] data1, op1, res_t1, res_f1, result1;

  // u0 datapath: separately programmable rails for precharge and evaluate
  assign res_t0 = prechrg0 ? rt0_pre : rt0_ev;
  assign res_f0 = prechrg0 ? rf0_pre : rf0_ev;
  // u1 datapath: clean WDDL array computing op ^ 8'h5A
  assign res_t1 = prechrg1 ? 8'h00 : (op1 ^ 8'h5A);
  assign res_f1 = prechrg1 ? 8'h00 : ~(op1 ^ 8'h5A);

  wddl_phase_ctrl u0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start0), .data_i(data0),
    .ready_o(ready0), .prechrg_o(prechrg0), .op_data_o(op0),
    .res_t_i(res_t0), .res_f_i(res_f0), .result_o(result0),
    .valid_o(valid0), .err_clr_i(err_clr0), .err_o(err0)
  );

  wddl_phase_ctrl #(.DATA_W(8), .PRE_CYC(3), .EVAL_CYC(2)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .data_i(data1),
    .ready_o(ready1), .prechrg_o(prechrg1), .op_data_o(op1),
    .res_t_i(res_t1), .res_f_i(res_f1), .result_o(result1),
    .valid_o(valid1), .err_clr_i(err_clr1), .err_o(err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: at the falling edge after rising edge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (valid0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL u0_unexpected_valid: got valid=1 expected no pending result (cyc=%0d)", cyc);
      end else begin
        e = q0.pop_front();
        chk("u0_result", result0, e.res);
        chk("u0_valid_cycle", cyc, e.cyc);
      end
    end
    if (valid1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL u1_unexpected_valid: got valid=1 expected no pending result (cyc=%0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("u1_result", result1, e.res);
        chk("u1_valid_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one u0 transaction; returns at the falling edge after acceptance
  task automatic go0(input logic [7:0] d, input logic [7:0] exp_res);
    int a;
    @(negedge clk);
    start0 = 1'b1;
    data0  = d;
    a = cyc + 1;
    q0.push_back('{exp_res, a + 2});
    @(negedge clk);
    start0 = 1'b0;
    data0  = 8'h00;
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (ready0 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("u0_idle_timeout", 32'(ready0), 32'd1);
  endtask

  initial begin
    int a, n;
    logic [7:0] dk;
    cyc = 0; n_vec = 0; n_fail = 0;
    rst_n = 1'b0;
    start0 = 0; data0 = 0; err_clr0 = 0;
    start1 = 0; data1 = 0; err_clr1 = 0;
    rt0_pre = 0; rf0_pre = 0; rt0_ev = 8'h3C; rf0_ev = 8'hC3;

    // Reset state
    #12;
    chk("rst_prechrg", 32'(prechrg0), 32'd1);
    chk("rst_ready",   32'(ready0),   32'd1);
    chk("rst_valid",   32'(valid0),   32'd0);
    chk("rst_err",     32'(err0),     32'd0);
    chk("rst_op",      32'(op0),      32'd0);
    chk("rst_result",  32'(result0),  32'd0);
    chk("rst_u1_prechrg", 32'(prechrg1), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Defaults: A5 in, rails 3C/C3, one precharge + one evaluate cycle
    go0(8'hA5, 8'h3C);
    chk("a_pre_after_accept", 32'(prechrg0), 32'd1);
    chk("a_ready_low",        32'(ready0),   32'd0);
    chk("a_op_data",          32'(op0),      32'hA5);
    @(negedge clk);
    chk("a_eval_phase",       32'(prechrg0), 32'd0);
    chk("a_valid_not_yet",    32'(valid0),   32'd0);
    @(negedge clk);
    chk("a_back_to_pre",      32'(prechrg0), 32'd1);
    chk("a_valid_pulse",      32'(valid0),   32'd1);
    chk("a_ready_in_valid",   32'(ready0),   32'd1);
    chk("a_err",              32'(err0),     32'd0);
    @(negedge clk);
    chk("a_valid_one_cycle",  32'(valid0),   32'd0);

    // u1: PRE=3/EVAL=2 phase pattern, start pulsed in PRE with FF ignored
    @(negedge clk);
    start1 = 1'b1; data1 = 8'h11;
    a = cyc + 1;
    q1.push_back('{8'h11 ^ 8'h5A, a + 5});
    @(negedge clk);
    start1 = 1'b0; data1 = 8'h00;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("b_prechrg_%0d", i), 32'(prechrg1), (i == 3 || i == 4) ? 32'd0 : 32'd1);
      if (i == 1) begin start1 = 1'b1; data1 = 8'hFF; end
      if (i == 2) begin start1 = 1'b0; data1 = 8'h00; end
    end
    chk("b_op_kept", 32'(op1), 32'h11);
    repeat (8) @(negedge clk);

    // u1: start held high -> one transaction per 6 cycles
    start1 = 1'b1; data1 = 8'h40;
    a = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      dk = 8'h40 + 8'(k);
      q1.push_back('{dk ^ 8'h5A, a + 6 * k + 5});
      n = 0;
      while (cyc < a + 6 * k && n < 40) begin
        @(negedge clk);
        n++;
      end
      data1 = dk + 8'h01;
    end
    start1 = 1'b0; data1 = 8'h00;
    repeat (8) @(negedge clk);

    // Rail violations on u0
    rt0_ev = 8'h01; rf0_ev = 8'h01;
    go0(8'h5C, 8'h01);
    wait_idle0();
    chk("d_err_eq_rails", 32'(err0), 32'(CHK));
    rt0_ev = 8'h3C; rf0_ev = 8'hC3;
    go0(8'h12, 8'h3C);
    wait_idle0();
    chk("d_err_sticky", 32'(err0), 32'(CHK));
    @(negedge clk);
    err_clr0 = 1'b1;
    @(negedge clk);
    err_clr0 = 1'b0;
    chk("d_err_cleared", 32'(err0), 32'd0);
    rt0_pre = 8'h01;
    go0(8'h34, 8'h3C);
    wait_idle0();
    chk("d_err_pre_rails", 32'(err0), 32'(CHK));
    rt0_pre = 8'h00;
    @(negedge clk);
    err_clr0 = 1'b1;
    @(negedge clk);
    err_clr0 = 1'b0;
    chk("d_err_cleared2", 32'(err0), 32'd0);

    // Asynchronous reset in the middle of EVAL
    go0(8'h77, 8'h3C);
    @(negedge clk);
    chk("e_in_eval", 32'(prechrg0), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("e_rst_prechrg", 32'(prechrg0), 32'd1);
    chk("e_rst_ready",   32'(ready0),   32'd1);
    chk("e_rst_valid",   32'(valid0),   32'd0);
    chk("e_rst_result",  32'(result0),  32'd0);
    chk("e_rst_op",      32'(op0),      32'd0);
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Drain
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/wddl_phase_ctrl.md
Name: wddl_phase_ctrl

Overview:
- Sequencer for a WDDL (wave dynamic differential logic) gate array, such as a bank of WDDL AND/OR cells.
- Accepts one operand word per transaction over a ready/start handshake and drives it to the datapath.
- Generates the shared precharge/evaluate signal for the array. Captures the true rail of the differential result at the end of evaluate and returns to precharge.
- Optionally checks rail integrity: all-zero in precharge, one-hot per bit pair in evaluate.

Parameters:
- DATA_W, 8, width of the operand word and of each result rail bus
- PRE_CYC, 1, cycles spent in precharge per transaction (legal range 1..255)
- EVAL_CYC, 1, cycles spent in evaluate per transaction (legal range 1..255)

Ports:
- clk_i  input  1  single clock; all state updates on its rising edge
- rst_n_i  input  1  asynchronous, active-low reset
- start_i  input  1  request a transaction; accepted only when ready_o=1
- data_i  input  DATA_W  operand word, sampled on the acceptance edge
- ready_o  output  1  controller idle and able to accept start_i
- prechrg_o  output  1  1 = precharge (datapath rails forced low), 0 = evaluate
- op_data_o  output  DATA_W  registered operand presented to the datapath
- res_t_i  input  DATA_W  true rail of the datapath result
- res_f_i  input  DATA_W  false (complement) rail of the datapath result
- result_o  output  DATA_W  captured true-rail result
- valid_o  output  1  one-cycle pulse: result_o updated
- err_clr_i  input  1  clears err_o
- err_o  output  1  sticky rail-violation flag

Behaviour:
- Reset (async, rst_n_i=0):
  - state=IDLE, prechrg_o=1, ready_o=1, valid_o=0, err_o=0
  - op_data_o=0, result_o=0, phase counter=0
  - Takes effect immediately, including mid-transaction; the datapath is forced back into precharge.
- States: IDLE, PRE, EVAL. All outputs are registered.
- IDLE:
  - prechrg_o=1, ready_o=1.
  - Edge with start_i=1: op_data_o<=data_i, counter<=PRE_CYC-1, state->PRE, ready_o<=0.
- PRE:
  - prechrg_o=1.
  - Counter decrements each edge.
  - At counter=0: state->EVAL, prechrg_o<=0, counter<=EVAL_CYC-1.
- EVAL:
  - prechrg_o=0.
  - Counter decrements each edge.
  - At counter=0 (capture edge): result_o<=res_t_i, valid_o<=1 for one cycle, prechrg_o<=1, ready_o<=1, state->IDLE.
- Latency: valid_o is high in the cycle starting PRE_CYC+EVAL_CYC edges after the acceptance edge. Defaults give 2 cycles. op_data_o stays stable from acceptance until the next acceptance.
- Back-to-back: start_i during the valid_o cycle is accepted, because ready_o=1 in that cycle. Maximum throughput is one transaction per PRE_CYC+EVAL_CYC+1 cycles.
- start_i while ready_o=0 is ignored and not queued; data_i is ignored.
- Datapath settling is the integrator's responsibility. EVAL_CYC must cover the combinational depth of the array.
- err_clr_i=1 clears err_o on that edge. If a violation is detected on the same edge, err_o is set (set wins).

Optional Feature:
- Macro: WDDL_RAIL_CHECK_EN
- Defined:
  - On the last PRE edge (counter=0 in PRE), any bit with res_t_i|res_f_i=1 sets err_o.
  - On the capture edge, any bit with res_t_i==res_f_i sets err_o.
  - err_o is sticky until err_clr_i.
- Not defined:
  - No checking logic is synthesised, err_o is tied to 0, and res_f_i is unused.
  - All other timing is identical.

Test Plan:
- Reset mid-EVAL: drive rst_n_i low asynchronously between edges -> prechrg_o=1, ready_o=1, valid_o=0 immediately; result_o=0.
- Defaults, data_i=8'hA5 accepted at edge 0, datapath rails return res_t=8'h3C / res_f=8'hC3 -> prechrg_o low for exactly 1 cycle; valid_o pulses in the cycle after edge 2; result_o=8'h3C; err_o=0.
- PRE_CYC=3, EVAL_CYC=2 -> prechrg_o high for 3 cycles after acceptance, low for 2; valid_o 5 cycles after acceptance; start_i held high throughout yields exactly one transaction per 6 cycles.
- start_i pulsed while in PRE with data_i=8'hFF -> ignored; op_data_o keeps the first operand; a single valid_o pulse.
- With WDDL_RAIL_CHECK_EN: res_t=res_f=8'h01 at the capture edge -> err_o=1 and stays 1 across the next clean transaction. err_clr_i pulse -> err_o=0. Nonzero rails on the last PRE edge -> err_o=1.
- Without WDDL_RAIL_CHECK_EN: same violating stimulus -> err_o stays 0; result_o and valid_o timing unchanged.
